// File: rtl/mode_pkg.sv
// mode_pkg: opcodes, mode encodings and default frame/link constants shared with the ground-link decoder
package mode_pkg;
    typedef enum logic [1:0] {
        MODE_IDLE    = 2'd0,
        MODE_COLLECT = 2'd1,
        MODE_OPERATE = 2'd2,
        MODE_SAFE    = 2'd3
    } mode_t;
    typedef enum logic {PS_OPCODE, PS_ARG} pstate_t;
    localparam logic [3:0] OP_START      = 4'd1;
    localparam logic [3:0] OP_OPERATE    = 4'd2;
    localparam logic [3:0] OP_STOP       = 4'd3;
    localparam logic [3:0] OP_SET_OFFSET = 4'd4;
    localparam logic [3:0] OP_SAFE       = 4'd5;
    localparam logic [3:0] OP_RESUME     = 4'd6;
    localparam int DEF_FRAME_TICKS  = 200;
    localparam int DEF_TX_SLOT      = 20;
    localparam int DEF_LINK_TIMEOUT = 50;
    // Unknown opcodes fall out as illegal because no term matches them
    function automatic logic op_legal(input logic [3:0] op, input mode_t mode);
        return (op == OP_START && mode == MODE_IDLE) || (op == OP_OPERATE && mode == MODE_COLLECT) ||
               op == OP_STOP || op == OP_SET_OFFSET || op == OP_SAFE ||
               (op == OP_RESUME && mode == MODE_SAFE);
    endfunction
endpackage

// File: rtl/mode_sequencer_if.sv
// mode_sequencer_if: ground-link command inputs, mission tick and mode/enable outputs
interface mode_sequencer_if #(
    parameter int CMD_W    = 8,
    parameter int OFFSET_W = 8
);
    logic                TIMESTAMP_TICK;
    logic                CMD_VALID;
    logic [CMD_W-1:0]    CMD_DATA;
    logic                DATA_en;
    logic                TX_en;
    logic                RX_en;
    logic [OFFSET_W-1:0] TX_PASS_OFFSET;
    logic [1:0]          MODE;
    logic                CMD_ERR;
    modport master (
        output TIMESTAMP_TICK, CMD_VALID, CMD_DATA,
        input  DATA_en, TX_en, RX_en, TX_PASS_OFFSET, MODE, CMD_ERR
    );
    modport slave (
        input  TIMESTAMP_TICK, CMD_VALID, CMD_DATA,
        output DATA_en, TX_en, RX_en, TX_PASS_OFFSET, MODE, CMD_ERR
    );
endinterface

// File: rtl/mode_cmd_parser.sv
// mode_cmd_parser: OPCODE/ARG command FSM producing one-cycle decoded strobes and the error pulse
module mode_cmd_parser
    import mode_pkg::*;
#(
    parameter int CMD_W    = 8,
    parameter int OFFSET_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    input  logic [CMD_W-1:0]    cmd_data,
    input  mode_t               mode,
    output logic                start,
    output logic                operate,
    output logic                stop,
    output logic                safe,
    output logic                resume,
    output logic                offset_wr,
    output logic                err,
    output logic [OFFSET_W-1:0] offset
);
    pstate_t state, state_n;
    logic [3:0] op;
    logic legal, take;

    assign op = cmd_data[CMD_W-1 -: 4];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= PS_OPCODE;
        else        state <= state_n;

    // In ARG the byte is an operand whatever its top nibble looks like
    always_comb begin
        legal     = op_legal(op, mode);
        take      = cmd_valid && state == PS_OPCODE && legal;
        start     = take && op == OP_START;
        operate   = take && op == OP_OPERATE;
        stop      = take && op == OP_STOP;
        safe      = take && op == OP_SAFE;
        resume    = take && op == OP_RESUME;
        offset_wr = cmd_valid && state == PS_ARG;
        offset    = OFFSET_W'(cmd_data);
        err       = cmd_valid && state == PS_OPCODE && !legal;
        state_n   = offset_wr ? PS_OPCODE : (take && op == OP_SET_OFFSET) ? PS_ARG : state;
    end
endmodule

// File: rtl/mode_sequencer.sv
// mode_sequencer: mode machine, frame counter, staged TX offset, link watchdog and TX/RX window decode
module mode_sequencer
    import mode_pkg::*;
#(
    parameter int CMD_W        = 8,
    parameter int OFFSET_W     = 8,
    parameter int FRAME_TICKS  = DEF_FRAME_TICKS,
    parameter int TX_SLOT      = DEF_TX_SLOT,
    parameter int LINK_TIMEOUT = DEF_LINK_TIMEOUT
) (
    input logic             CLK_48MHZ,
    input logic             RESET_N,
    mode_sequencer_if.slave bus
);
    localparam int FW = $clog2(FRAME_TICKS);
    localparam int TW = $clog2(LINK_TIMEOUT + 1);

    mode_t mode, mode_n;
    logic [FW-1:0] frame, frame_n;
    logic [TW-1:0] timer, timer_n;
    logic [OFFSET_W-1:0] offset, offset_n, staged, staged_n, arg;
    logic pending, pending_n, tx, rx, data, err_q;
    logic start, operate, stop, safe, resume, offset_wr, err;
    logic wrap, expire, apply, win, tx_n, rx_n, data_n;

    mode_cmd_parser #(.CMD_W(CMD_W), .OFFSET_W(OFFSET_W)) u_parser (
        .clk(CLK_48MHZ), .rst_n(RESET_N), .cmd_valid(bus.CMD_VALID), .cmd_data(bus.CMD_DATA),
        .mode(mode), .start(start), .operate(operate), .stop(stop), .safe(safe), .resume(resume),
        .offset_wr(offset_wr), .err(err), .offset(arg)
    );

    // Enables are decoded from next-state values so both land on the same edge as the state they describe
    always_comb begin
        wrap      = mode == MODE_OPERATE && bus.TIMESTAMP_TICK && frame == FW'(FRAME_TICKS - 1);
        expire    = wrap && timer >= TW'(LINK_TIMEOUT - 1) && !bus.CMD_VALID;
        mode_n    = (start || resume) ? MODE_COLLECT : operate ? MODE_OPERATE : stop ? MODE_IDLE :
                    (safe || expire) ? MODE_SAFE : mode;
        frame_n   = (mode != MODE_OPERATE || mode_n != MODE_OPERATE || wrap) ? '0 :
                    frame + FW'(bus.TIMESTAMP_TICK);
        timer_n   = (start || operate || stop || safe || resume || expire || (bus.CMD_VALID && !err)) ? '0 :
                    (wrap && timer < TW'(LINK_TIMEOUT)) ? timer + TW'(1) : timer;
        apply     = wrap && pending && !(safe || stop);
        offset_n  = apply ? staged : offset;
        staged_n  = offset_wr ? arg : staged;
        pending_n = offset_wr || (pending && !apply);
        win       = 32'(frame_n) >= 32'(offset_n) && 32'(frame_n) < 32'(offset_n) + 32'(TX_SLOT);
        tx_n      = mode_n == MODE_OPERATE && win;
        rx_n      = mode_n == MODE_SAFE || (mode_n == MODE_OPERATE && !win);
        data_n    = mode_n != MODE_IDLE;
    end

    always_ff @(posedge CLK_48MHZ or negedge RESET_N)
        if (!RESET_N) begin
            mode    <= MODE_IDLE;
            frame   <= '0;
            timer   <= '0;
            offset  <= '0;
            staged  <= '0;
            pending <= 1'b0;
            tx      <= 1'b0;
            rx      <= 1'b0;
            data    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            mode    <= mode_n;
            frame   <= frame_n;
            timer   <= timer_n;
            offset  <= offset_n;
            staged  <= staged_n;
            pending <= pending_n;
            tx      <= tx_n;
            rx      <= rx_n;
            data    <= data_n;
            err_q   <= err;
        end

    assign bus.MODE           = mode;
    assign bus.DATA_en        = data;
    assign bus.TX_en          = tx;
    assign bus.RX_en          = rx;
    assign bus.TX_PASS_OFFSET = offset;
    assign bus.CMD_ERR        = err_q;
endmodule
